// File: rtl/alu_op_issuer_if.sv
// Request/response bundle between an instruction source and the ALU issuer.
// Valid/ready: a transfer happens on a rising edge where valid && ready; the sender holds valid and payload stable until then.
interface alu_op_issuer_if;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_opcode;
    logic [5:0]  req_funct;
    logic [31:0] req_rs_val;
    logic [31:0] req_rt_val;
    logic [15:0] req_imm;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_branch_taken;
    logic        rsp_illegal;

    modport slave (
        input  req_valid, req_opcode, req_funct, req_rs_val, req_rt_val, req_imm,
        output req_ready,
        output rsp_valid, rsp_result, rsp_zero, rsp_branch_taken, rsp_illegal,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_opcode, req_funct, req_rs_val, req_rt_val, req_imm,
        input  req_ready,
        input  rsp_valid, rsp_result, rsp_zero, rsp_branch_taken, rsp_illegal,
        output rsp_ready
    );
endinterface

// File: rtl/alu_op_issuer.sv
// Issue-side controller for a combinational 32-bit ALU: decodes one request, drives registered
// operands for one EXEC cycle, captures the result and hands it back over valid/ready.
module alu_op_issuer #(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_op_issuer_if.slave     bus,
    output logic [31:0]        alu_src1,
    output logic [31:0]        alu_src2,
    output logic [2:0]         alu_control,
    input  logic [31:0]        alu_result,
    input  logic               alu_zero,
    output logic [CNT_W-1:0]   ops_done,
    output logic [1:0]         dbg_state
);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_NOR = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        src1_q, src1_d;
    logic [31:0]        src2_q, src2_d;
    logic [2:0]         ctrl_q, ctrl_d;
    logic               beq_q, beq_d;
    logic               bne_q, bne_d;
    logic [31:0]        result_q, result_d;
    logic               zero_q, zero_d;
    logic               taken_q, taken_d;
    logic               illegal_q, illegal_d;
    logic [CNT_W-1:0]   ops_q, ops_d;

    logic               dec_legal;
    logic [2:0]         dec_ctrl;
    logic [31:0]        dec_src2;
    logic               dec_beq;
    logic               dec_bne;
    logic [31:0]        imm_sext;
    logic [31:0]        imm_zext;

    assign imm_sext = {{16{bus.req_imm[15]}}, bus.req_imm};
    assign imm_zext = {16'h0000, bus.req_imm};

    always_comb begin
        dec_legal = 1'b0;
        dec_ctrl  = ALU_ADD;
        dec_src2  = bus.req_rt_val;
        dec_beq   = 1'b0;
        dec_bne   = 1'b0;
        case (bus.req_opcode)
            6'h00: begin
                dec_legal = 1'b1;
                case (bus.req_funct)
                    6'h20, 6'h21: dec_ctrl = ALU_ADD;
                    6'h22, 6'h23: dec_ctrl = ALU_SUB;
                    6'h24:        dec_ctrl = ALU_AND;
                    6'h25:        dec_ctrl = ALU_OR;
                    6'h26:        dec_ctrl = ALU_XOR;
                    6'h27:        dec_ctrl = ALU_NOR;
                    default:      dec_legal = 1'b0;
                endcase
            end
            6'h08, 6'h09: begin
                dec_legal = 1'b1;
                dec_ctrl  = ALU_ADD;
                dec_src2  = imm_sext;
            end
            // Logical immediates zero-extend, unlike the arithmetic ones.
            6'h0C: begin
                dec_legal = 1'b1;
                dec_ctrl  = ALU_AND;
                dec_src2  = imm_zext;
            end
            6'h0D: begin
                dec_legal = 1'b1;
                dec_ctrl  = ALU_OR;
                dec_src2  = imm_zext;
            end
            6'h0E: begin
                dec_legal = 1'b1;
                dec_ctrl  = ALU_XOR;
                dec_src2  = imm_zext;
            end
            6'h04: begin
                dec_legal = 1'b1;
                dec_ctrl  = ALU_SUB;
                dec_beq   = 1'b1;
            end
            6'h05: begin
                dec_legal = 1'b1;
                dec_ctrl  = ALU_SUB;
                dec_bne   = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        src1_d    = src1_q;
        src2_d    = src2_q;
        ctrl_d    = ctrl_q;
        beq_d     = beq_q;
        bne_d     = bne_q;
        result_d  = result_q;
        zero_d    = zero_q;
        taken_d   = taken_q;
        illegal_d = illegal_q;
        ops_d     = ops_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (dec_legal) begin
                        src1_d  = bus.req_rs_val;
                        src2_d  = dec_src2;
                        ctrl_d  = dec_ctrl;
                        beq_d   = dec_beq;
                        bne_d   = dec_bne;
                        state_d = S_EXEC;
                    end else begin
                        // Illegal ops never reach the ALU; ALU-facing registers keep the last issue.
                        result_d  = 32'h0000_0000;
                        zero_d    = 1'b0;
                        taken_d   = 1'b0;
                        illegal_d = 1'b1;
                        state_d   = S_RESP;
                    end
                end
            end
            S_EXEC: begin
                result_d  = alu_result;
                zero_d    = alu_zero;
                taken_d   = (beq_q & alu_zero) | (bne_q & ~alu_zero);
                illegal_d = 1'b0;
                state_d   = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    ops_d   = ops_q + CNT_W'(1);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            src1_q    <= '0;
            src2_q    <= '0;
            ctrl_q    <= '0;
            beq_q     <= 1'b0;
            bne_q     <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
            ops_q     <= '0;
        end else begin
            state_q   <= state_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            ctrl_q    <= ctrl_d;
            beq_q     <= beq_d;
            bne_q     <= bne_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
            ops_q     <= ops_d;
        end
    end

    assign bus.req_ready        = (state_q == S_IDLE);
    assign bus.rsp_valid        = (state_q == S_RESP);
    assign bus.rsp_result       = result_q;
    assign bus.rsp_zero         = zero_q;
    assign bus.rsp_branch_taken = taken_q;
    assign bus.rsp_illegal      = illegal_q;
    assign alu_src1             = src1_q;
    assign alu_src2             = src2_q;
    assign alu_control          = ctrl_q;
    assign ops_done             = ops_q;
    assign dbg_state            = state_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer: a driver pushes hand-computed responses into a queue and a
// negedge monitor pops and compares each handed-off response.
module tb_alu_op_issuer;
    // Narrow counter so the wrap-around is reached in a handful of operations.
    localparam int CNT_W = 4;
    localparam int W     = 38;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       alu_src1;
    logic [31:0]       alu_src2;
    logic [2:0]        alu_control;
    logic [31:0]       alu_result;
    logic              alu_zero;
    logic [CNT_W-1:0]  ops_done;
    logic [1:0]        dbg_state;

    alu_op_issuer_if bus ();

    alu_op_issuer #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .alu_src1    (alu_src1),
        .alu_src2    (alu_src2),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .ops_done    (ops_done),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    // Reference combinational ALU attached to the issuer.
    always_comb begin
        alu_result = 32'h0;
        case (alu_control)
            3'b000:  alu_result = alu_src1 + alu_src2;
            3'b001:  alu_result = alu_src1 - alu_src2;
            3'b010:  alu_result = alu_src1 & alu_src2;
            3'b011:  alu_result = alu_src1 | alu_src2;
            3'b100:  alu_result = alu_src1 ^ alu_src2;
            3'b101:  alu_result = ~(alu_src1 | alu_src2);
            default: alu_result = 32'h0;
        endcase
        alu_zero = (alu_result == 32'h0);
    end

    // Expected entry: {alu_control, illegal, branch_taken, zero, result}
    logic [W-1:0]      exp_q[$];
    logic [W-1:0]      mon_e;
    int                checks   = 0;
    int                failures = 0;
    logic [CNT_W-1:0]  exp_ops  = '0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp actual=%h required=none", bus.rsp_result);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_result",  bus.rsp_result,               mon_e[31:0]);
                check("rsp_zero",    32'(bus.rsp_zero),            32'(mon_e[32]));
                check("rsp_taken",   32'(bus.rsp_branch_taken),    32'(mon_e[33]));
                check("rsp_illegal", 32'(bus.rsp_illegal),         32'(mon_e[34]));
                check("alu_control", 32'(alu_control),             32'(mon_e[37:35]));
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the edge that accepted the request.
    task automatic send(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [15:0] imm, input logic [2:0] ctrl,
                        input logic ill, input logic tk, input logic zr, input logic [31:0] res);
        int n = 0;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL req_ready_timeout actual=0 required=1");
        end
        exp_q.push_back({ctrl, ill, tk, zr, res});
        bus.req_valid  = 1'b1;
        bus.req_opcode = op;
        bus.req_funct  = fn;
        bus.req_rs_val = rs;
        bus.req_rt_val = rt;
        bus.req_imm    = imm;
        @(posedge clk); #1;
        bus.req_valid  = 1'b0;
    endtask

    task automatic check_latency(input logic ill);
        if (ill) begin
            check("lat_illegal_resp", 32'(bus.rsp_valid), 32'd1);
        end else begin
            check("lat_exec_no_rsp", 32'(bus.rsp_valid), 32'd0);
            @(posedge clk); #1;
            check("lat_legal_resp", 32'(bus.rsp_valid), 32'd1);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(exp_q.size() == 0 && bus.req_ready === 1'b1) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL handoff_timeout actual=pending required=idle");
        end
    endtask

    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [15:0] imm, input logic [2:0] ctrl,
                       input logic ill, input logic tk, input logic zr, input logic [31:0] res);
        send(op, fn, rs, rt, imm, ctrl, ill, tk, zr, res);
        check_latency(ill);
        wait_idle();
        exp_ops = exp_ops + CNT_W'(1);
    endtask

    logic [31:0] snap_result;
    logic        snap_zero;

    initial begin
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_opcode = '0;
        bus.req_funct  = '0;
        bus.req_rs_val = '0;
        bus.req_rt_val = '0;
        bus.req_imm    = '0;
        bus.rsp_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_req_ready",   32'(bus.req_ready),   32'd1);
        check("reset_rsp_valid",   32'(bus.rsp_valid),   32'd0);
        check("reset_rsp_result",  bus.rsp_result,       32'd0);
        check("reset_rsp_illegal", 32'(bus.rsp_illegal), 32'd0);
        check("reset_alu_control", 32'(alu_control),     32'd0);
        check("reset_alu_src1",    alu_src1,             32'd0);
        check("reset_ops_done",    32'(ops_done),        32'd0);
        check("reset_state",       32'(dbg_state),       32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        //   op     fn     rs            rt            imm       ctrl  ill   tk    zr    result
        run(6'h00, 6'h20, 32'd7,        32'd5,        16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 32'd12);
        run(6'h00, 6'h22, 32'h1234,     32'h1234,     16'h0000, 3'd1, 1'b0, 1'b0, 1'b1, 32'd0);
        run(6'h04, 6'h00, 32'h1234,     32'h1234,     16'h0000, 3'd1, 1'b0, 1'b1, 1'b1, 32'd0);
        run(6'h05, 6'h00, 32'd3,        32'd3,        16'h0000, 3'd1, 1'b0, 1'b0, 1'b1, 32'd0);
        run(6'h05, 6'h00, 32'd5,        32'd3,        16'h0000, 3'd1, 1'b0, 1'b1, 1'b0, 32'd2);
        run(6'h04, 6'h00, 32'd1,        32'd2,        16'h0000, 3'd1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
        run(6'h08, 6'h00, 32'd0,        32'h55,       16'hFFFF, 3'd0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
        run(6'h09, 6'h00, 32'd10,       32'd0,        16'hFFFE, 3'd0, 1'b0, 1'b0, 1'b0, 32'd8);
        run(6'h0D, 6'h00, 32'd0,        32'd0,        16'hFFFF, 3'd3, 1'b0, 1'b0, 1'b0, 32'h0000_FFFF);
        run(6'h0C, 6'h00, 32'hFFFF_FFFF, 32'd0,       16'h8001, 3'd2, 1'b0, 1'b0, 1'b0, 32'h0000_8001);
        run(6'h0E, 6'h00, 32'h0000_FFFF, 32'd0,       16'hFFFF, 3'd4, 1'b0, 1'b0, 1'b1, 32'd0);
        // Illegal ops: result/zero forced to 0, alu_control keeps the previous XOR issue.
        run(6'h3F, 6'h00, 32'd1,        32'd1,        16'h0000, 3'd4, 1'b1, 1'b0, 1'b0, 32'd0);
        run(6'h00, 6'h00, 32'd1,        32'd1,        16'h0000, 3'd4, 1'b1, 1'b0, 1'b0, 32'd0);
        run(6'h00, 6'h21, 32'hFFFF_FFFF, 32'd2,       16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 32'd1);
        run(6'h00, 6'h23, 32'd0,        32'd1,        16'h0000, 3'd1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
        run(6'h00, 6'h24, 32'hF0F0_F0F0, 32'hFF00_FF00, 16'h0000, 3'd2, 1'b0, 1'b0, 1'b0, 32'hF000_F000);
        run(6'h00, 6'h26, 32'hF0F0_F0F0, 32'hFF00_FF00, 16'h0000, 3'd4, 1'b0, 1'b0, 1'b0, 32'h0FF0_0FF0);
        run(6'h00, 6'h27, 32'hF0F0_F0F0, 32'hFF00_FF00, 16'h0000, 3'd5, 1'b0, 1'b0, 1'b0, 32'h000F_000F);
        check("ops_after_vectors", 32'(ops_done), 32'(exp_ops));

        // Backpressure: response held while a competing request waits.
        bus.rsp_ready = 1'b0;
        send(6'h00, 6'h25, 32'hF0F0_F0F0, 32'hFF00_FF00, 16'h0000, 3'd3, 1'b0, 1'b0, 1'b0, 32'hFFF0_FFF0);
        check_latency(1'b0);
        snap_result = bus.rsp_result;
        snap_zero   = bus.rsp_zero;
        bus.req_valid  = 1'b1;
        bus.req_opcode = 6'h00;
        bus.req_funct  = 6'h20;
        bus.req_rs_val = 32'd99;
        bus.req_rt_val = 32'd1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_rsp_valid",  32'(bus.rsp_valid), 32'd1);
            check("bp_rsp_result", bus.rsp_result,     snap_result);
            check("bp_rsp_zero",   32'(bus.rsp_zero),  32'(snap_zero));
            check("bp_req_ready",  32'(bus.req_ready), 32'd0);
            check("bp_ops_held",   32'(ops_done),      32'(exp_ops));
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        wait_idle();
        exp_ops = exp_ops + CNT_W'(1);
        check("bp_ops_done", 32'(ops_done), 32'(exp_ops));
        @(posedge clk); #1;
        check("bp_no_extra_accept", 32'(bus.rsp_valid) | 32'(dbg_state), 32'd0);

        // Reset while an op sits in EXEC: nothing may come back.
        send(6'h00, 6'h20, 32'd1, 32'd1, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 32'd2);
        check("mid_exec_state", 32'(dbg_state), 32'd1);
        void'(exp_q.pop_back());
        rst_n = 1'b0;
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_ops_done",  32'(ops_done),      32'd0);
        check("rst_alu_ctrl",  32'(alu_control),   32'd0);
        exp_ops = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_no_rsp", 32'(bus.rsp_valid), 32'd0);

        // Counter wrap: 2^CNT_W - 1 then back to 0.
        for (int i = 1; i <= 16; i++) begin
            run(6'h00, 6'h20, 32'(i), 32'(2 * i), 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 32'(3 * i));
            if (i == 15) check("ops_at_max", 32'(ops_done), 32'hF);
        end
        check("ops_wrapped", 32'(ops_done), 32'h0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
